fpu_issue_sequencer: RTL and testbench

- Sequences CPU-side 8087 instructions into FPU8087_Direct, one at a time.
- Buffers up to DEPTH requests (opcode, modrm, 80-bit operand, 32-bit integer operand) in a FIFO.
- Per instruction: pulses the FPU execute strobe for exactly one cycle, tracks busy/ready completion with a watchdog, and returns result/error/timeout through a one-entry response register with valid/ready handshake.
- Sits between the CPU escape-opcode decoder and the FPU core's cpu_* port group.

---
 rtl/fpu_seq_pkg.sv | 16 +
 rtl/fpu_req_fifo.sv | 36 +++
 rtl/fpu_issue_sequencer.sv | 116 +++++++++++
 tb/tb_fpu_issue_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_seq_pkg.sv
// fpu_seq_pkg: shared state encoding, request bundle and defaults for the FPU issue sequencer
package fpu_seq_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  modrm;
    logic [79:0] data;
    logic [31:0] int_data;
  } fpu_req_t;
  localparam int REQ_W = $bits(fpu_req_t);
  localparam int DEF_TIMEOUT = 1023;
endpackage

// File: rtl/fpu_req_fifo.sv
// fpu_req_fifo: DEPTH x W synchronous FIFO with occupancy count.
// Ports: clk, reset (sync active-low), push/din, pop/dout (head, show-ahead), count.
// Caller guarantees no push when full and no pop when empty.
module fpu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/fpu_issue_sequencer.sv
// fpu_issue_sequencer: queues 8087 requests and issues them one at a time to the FPU core.
// Ports: clk, reset (sync active-low);
//   req_*  : request stream in (valid/ready), buffered in a DEPTH-entry FIFO;
//   fpu_*  : operand/strobe outputs to the core, ready/error/result inputs from it;
//   rsp_*  : one-entry response register (valid/ready) with captured result, error, timeout;
//   busy   : FSM active or requests queued; pending: FIFO occupancy.
module fpu_issue_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W    = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             req_opcode,
  input  logic [7:0]             req_modrm,
  input  logic [79:0]            req_data,
  input  logic [31:0]            req_int_data,
  output logic [7:0]             fpu_opcode,
  output logic [7:0]             fpu_modrm,
  output logic [79:0]            fpu_data_in,
  output logic [31:0]            fpu_int_data_in,
  output logic                   fpu_execute,
  input  logic                   fpu_ready,
  input  logic                   fpu_error,
  input  logic [79:0]            fpu_data_out,
  input  logic [31:0]            fpu_int_data_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [79:0]            rsp_data,
  output logic [31:0]            rsp_int_data,
  output logic                   rsp_error,
  output logic                   rsp_timeout,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pending
);
  localparam int PW = $clog2(DEPTH) + 1;
  state_t          state;
  fpu_req_t        head;
  fpu_req_t        req;
  logic [TO_W-1:0] wdog;
  logic            seen_busy;
  logic            push;
  logic            pop;
  assign req       = '{opcode: req_opcode, modrm: req_modrm, data: req_data, int_data: req_int_data};
  assign req_ready = pending != PW'(DEPTH);
  assign push      = req_valid && req_ready;
  // An unconsumed response blocks the next issue, so capture never races a response pop.
  assign pop       = state == IDLE && pending != '0 && !rsp_valid;
  assign busy      = state != IDLE || pending != '0;
  fpu_req_fifo #(.DEPTH(DEPTH), .W(REQ_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (req),
    .pop   (pop),
    .dout  (head),
    .count (pending)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      fpu_execute     <= 1'b0;
      fpu_opcode      <= '0;
      fpu_modrm       <= '0;
      fpu_data_in     <= '0;
      fpu_int_data_in <= '0;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
      rsp_int_data    <= '0;
      rsp_error       <= 1'b0;
      rsp_timeout     <= 1'b0;
      wdog            <= '0;
      seen_busy       <= 1'b0;
    end else begin
      fpu_execute <= 1'b0;
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          {fpu_opcode, fpu_modrm, fpu_data_in, fpu_int_data_in} <= head;
          fpu_execute <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          // A core already busy when the strobe lands counts as having dropped ready.
          wdog      <= '0;
          seen_busy <= ~fpu_ready;
          state     <= WAIT;
        end
        WAIT: begin
          wdog <= wdog + 1'b1;
          if (!fpu_ready) seen_busy <= 1'b1;
          if (fpu_ready && seen_busy) begin
            rsp_data     <= fpu_data_out;
            rsp_int_data <= fpu_int_data_out;
            rsp_error    <= fpu_error;
            rsp_timeout  <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= IDLE;
          end else if (wdog == TO_W'(TIMEOUT)) begin
            rsp_data     <= '0;
            rsp_int_data <= '0;
            rsp_error    <= 1'b1;
            rsp_timeout  <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// tb_fpu_issue_sequencer: directed vector table plus multi-cycle corner sequences for fpu_issue_sequencer
module tb_fpu_issue_sequencer;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 1023;
  localparam logic [79:0] FLD1 = 80'h3FFF8000000000000000;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_opcode = '0;
  logic [7:0]  req_modrm = '0;
  logic [79:0] req_data = '0;
  logic [31:0] req_int_data = '0;
  logic [7:0]  fpu_opcode;
  logic [7:0]  fpu_modrm;
  logic [79:0] fpu_data_in;
  logic [31:0] fpu_int_data_in;
  logic        fpu_execute;
  logic        fpu_ready;
  logic        fpu_error;
  logic [79:0] fpu_data_out;
  logic [31:0] fpu_int_data_out;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [79:0] rsp_data;
  logic [31:0] rsp_int_data;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        busy;
  logic [2:0]  pending;
  always #5 clk = ~clk;
  fpu_issue_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TO_W(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode), .req_modrm(req_modrm),
    .req_data(req_data), .req_int_data(req_int_data),
    .fpu_opcode(fpu_opcode), .fpu_modrm(fpu_modrm), .fpu_data_in(fpu_data_in),
    .fpu_int_data_in(fpu_int_data_in), .fpu_execute(fpu_execute), .fpu_ready(fpu_ready),
    .fpu_error(fpu_error), .fpu_data_out(fpu_data_out), .fpu_int_data_out(fpu_int_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_int_data(rsp_int_data),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .busy(busy), .pending(pending)
  );
  // FPU core model: drops ready for m_delay cycles after each strobe (or never if m_nodrop),
  // m_hold forces ready low; result is FLD1 for D9/E8, else ~operand; int result is operand+1.
  int          m_delay = 1;
  logic        m_nodrop = 1'b0;
  logic        m_hold = 1'b0;
  logic        m_err = 1'b0;
  int          cnt = 0;
  int          exec_cnt = 0;
  int          wide_cnt = 0;
  logic        exec_q = 1'b0;
  logic [7:0]  l_op = '0;
  logic [7:0]  l_modrm = '0;
  logic [79:0] l_data = '0;
  logic [31:0] l_int = '0;
  always @(posedge clk) begin
    exec_q <= fpu_execute;
    if (fpu_execute) begin
      exec_cnt <= exec_cnt + 1;
      if (exec_q) wide_cnt <= wide_cnt + 1;
      l_op    <= fpu_opcode;
      l_modrm <= fpu_modrm;
      l_data  <= fpu_data_in;
      l_int   <= fpu_int_data_in;
      cnt     <= m_nodrop ? 0 : m_delay;
    end else if (cnt > 0) cnt <= cnt - 1;
  end
  assign fpu_ready        = cnt == 0 && !m_hold;
  assign fpu_data_out     = (l_op == 8'hD9 && l_modrm == 8'hE8) ? FLD1 : ~l_data;
  assign fpu_int_data_out = l_int + 32'd1;
  assign fpu_error        = m_err;
  int total = 0;
  int bad = 0;
  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // called at a negedge; the push happens at the following posedge, returns at the next negedge
  task automatic send(input logic [7:0] op, input logic [7:0] mr, input logic [79:0] d, input logic [31:0] iv);
    req_opcode   = op;
    req_modrm    = mr;
    req_data     = d;
    req_int_data = iv;
    req_valid    = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic accept();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask
  typedef struct {
    logic [7:0]  op;
    logic [7:0]  modrm;
    logic [79:0] data;
    logic [31:0] ival;
    int          delay;
    logic        err;
    logic [79:0] exp_data;
    logic [31:0] exp_int;
  } vec_t;
  vec_t vecs[5];
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end
  initial begin
    int n, ts, e0, e1, got, stable;
    logic [79:0] hold_d;
    vecs[0] = '{8'hD9, 8'hE8, 80'h0, 32'h0, 3, 1'b0, FLD1, 32'h1};
    vecs[1] = '{8'hD8, 8'hC1, 80'h4000C000000000000000, 32'h12345678, 1, 1'b0, 80'hBFFF3FFFFFFFFFFFFFFF, 32'h12345679};
    vecs[2] = '{8'hDD, 8'h06, 80'h0123456789ABCDEF0123, 32'hFFFFFFFF, 5, 1'b1, 80'hFEDCBA9876543210FEDC, 32'h0};
    vecs[3] = '{8'hDF, 8'h2E, 80'hFFFFFFFFFFFFFFFFFFFF, 32'h7FFFFFFF, 2, 1'b0, 80'h0, 32'h80000000};
    vecs[4] = '{8'hDB, 8'h28, 80'h3FFF8000000000000000, 32'h0, 8, 1'b0, 80'hC0007FFFFFFFFFFFFFFF, 32'h1};
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_pending", pending, 0);
    chk("rst_exec", fpu_execute, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_opcode", fpu_opcode, 0);
    chk("rst_timeout", rsp_timeout, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      m_delay = vecs[i].delay;
      m_err   = vecs[i].err;
      e0 = exec_cnt;
      send(vecs[i].op, vecs[i].modrm, vecs[i].data, vecs[i].ival);
      n = 1;
      ts = 0;
      while (!rsp_valid && n < 3000) begin
        if (fpu_execute && ts == 0) ts = n;
        @(negedge clk);
        n++;
      end
      chk("vec_strobe_lat", ts, 2);
      chk("vec_rsp_lat", n, vecs[i].delay + 4);
      chk("vec_data", rsp_data, vecs[i].exp_data);
      chk("vec_int", rsp_int_data, vecs[i].exp_int);
      chk("vec_err", rsp_error, vecs[i].err);
      chk("vec_timeout", rsp_timeout, 0);
      chk("vec_exec_once", exec_cnt - e0, 1);
      accept();
      chk("vec_rsp_clr", rsp_valid, 0);
      chk("vec_pending0", pending, 0);
      chk("vec_idle", busy, 0);
    end
    m_err = 1'b0;
    m_hold = 1'b1;
    m_delay = 2;
    rsp_ready = 1'b1;
    e0 = exec_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("fill_ready", req_ready, 1);
      send(8'hD8, 8'hC0 + 8'(i), 80'(i), 32'(100 + i));
    end
    chk("fill_pending", pending, DEPTH);
    chk("fill_full", req_ready, 0);
    chk("fill_exec", exec_cnt - e0, 1);
    send(8'hDE, 8'hC9, 80'hDEAD, 32'd999);
    chk("fill_drop", pending, DEPTH);
    m_hold = 1'b0;
    got = 0;
    n = 0;
    while (got < 5 && n < 500) begin
      if (rsp_valid) begin
        chk("fill_order_int", rsp_int_data, 32'(101 + got));
        chk("fill_order_data", rsp_data, ~80'(got));
        got++;
      end
      @(negedge clk);
      n++;
    end
    rsp_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("fill_count", got, 5);
    chk("fill_exec_total", exec_cnt - e0, 5);
    chk("fill_pending0", pending, 0);
    m_delay = 1;
    e0 = exec_cnt;
    send(8'hD8, 8'hC2, 80'h11, 32'h5);
    send(8'hD8, 8'hC3, 80'h22, 32'h6);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp1", rsp_valid, 1);
    hold_d = rsp_data;
    stable = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_data !== hold_d || !rsp_valid) stable = 0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_exec_held", exec_cnt - e0, 1);
    chk("bp_data", hold_d, ~80'h11);
    chk("bp_pending", pending, 1);
    accept();
    n = 1;
    while (!fpu_execute && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_gap", n, 2);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp2_int", rsp_int_data, 32'h7);
    accept();
    m_nodrop = 1'b1;
    send(8'hD9, 8'hF0, 80'h5, 32'h0);
    n = 1;
    while (!rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("to_lat", n, TIMEOUT + 4);
    chk("to_flag", rsp_timeout, 1);
    chk("to_err", rsp_error, 1);
    chk("to_data", rsp_data, 0);
    accept();
    m_nodrop = 1'b0;
    m_delay = 2;
    send(8'hD9, 8'hE8, 80'h0, 32'h0);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_next_data", rsp_data, FLD1);
    chk("to_next_flag", rsp_timeout, 0);
    chk("to_next_err", rsp_error, 0);
    accept();
    m_hold = 1'b1;
    m_delay = 1;
    for (int i = 0; i < 4; i++) send(8'hDC, 8'hC0 + 8'(i), 80'(i + 7), 32'(i));
    repeat (2) @(negedge clk);
    chk("rmid_pending", pending, 3);
    chk("rmid_busy", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rmid_pending0", pending, 0);
    chk("rmid_rsp_valid", rsp_valid, 0);
    chk("rmid_busy0", busy, 0);
    chk("rmid_exec", fpu_execute, 0);
    e1 = exec_cnt;
    m_hold = 1'b0;
    repeat (30) @(negedge clk);
    chk("rmid_no_exec", exec_cnt - e1, 0);
    chk("rmid_no_rsp", rsp_valid, 0);
    send(8'hD8, 8'hC4, 80'h33, 32'h9);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rmid_recover_data", rsp_data, ~80'h33);
    chk("rmid_recover_int", rsp_int_data, 32'hA);
    accept();
    chk("strobe_width", wide_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
